// File: rtl/irq_seq_ctrl_if.sv
// Bundle between the interrupt sequencer and its surroundings (C0 irq regs + fetch/retire).
//  master : environment side (drives request summary, C0 regs view and retire info)
//  slave  : irq_seq_ctrl side (drives C0 op/epc write, fetch stall/redirect, depth, err)
// Signals:
//  ivld, inum, ie, epc          C0 pending-request summary, global enable, return address
//  instr_done, pc_next, eret    retire boundary info
//  rc0_en, rc0_op               C0 register enable and op code
//  epc_we, epc_w                epc write port
//  stall, redirect, redirect_pc fetch control
//  depth, err                   nesting depth and error pulse
interface irq_seq_ctrl_if #(
    parameter int unsigned NBIT_IRQ = 5,
    parameter int unsigned DEPTH_W  = 3
);
    logic                ivld;
    logic [NBIT_IRQ-1:0] inum;
    logic [31:0]         ie;
    logic [31:0]         epc;
    logic                instr_done;
    logic [31:0]         pc_next;
    logic                eret;

    logic                rc0_en;
    logic [1:0]          rc0_op;
    logic                epc_we;
    logic [31:0]         epc_w;
    logic                stall;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic [DEPTH_W-1:0]  depth;
    logic                err;

    modport master (
        output ivld, inum, ie, epc, instr_done, pc_next, eret,
        input  rc0_en, rc0_op, epc_we, epc_w, stall, redirect, redirect_pc, depth, err
    );

    modport slave (
        input  ivld, inum, ie, epc, instr_done, pc_next, eret,
        output rc0_en, rc0_op, epc_we, epc_w, stall, redirect, redirect_pc, depth, err
    );
endinterface

// File: rtl/irq_seq_ctrl.sv
// Interrupt entry/return sequencer around the C0 interrupt register block.
// At a retire boundary it either starts an ERET (RET) or an interrupt entry (ENTER -> VEC),
// driving the C0 op code, the epc write and a one-cycle fetch redirect. Tracks nesting depth.
// Ports:
//  clk    clock; state updates on the falling edge, matching the C0 registers
//  rst_n  asynchronous active-low reset
//  bus    irq_seq_ctrl_if slave modport (see interface header for signal list)
// All outputs are registered: each is loaded on the edge that enters the state it belongs to.
module irq_seq_ctrl #(
    parameter int unsigned NBIT_IRQ  = 5,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0800,
    parameter int unsigned VEC_SHIFT = 4,
    parameter int unsigned MAX_DEPTH = 4,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1),
    parameter logic [1:0]  OP_NONE   = 2'd0,
    parameter logic [1:0]  OP_IRQ    = 2'd1,
    parameter logic [1:0]  OP_RET    = 2'd2
) (
    input logic           clk,
    input logic           rst_n,
    irq_seq_ctrl_if.slave bus
);
    localparam logic [DEPTH_W-1:0] DepthMax = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DepthOne = DEPTH_W'(1);

    typedef enum logic [1:0] {StIdle, StEnter, StVec, StRet} state_e;

    state_e              state_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic                guard_q;
    logic [NBIT_IRQ-1:0] num_q;
    logic [1:0]          rc0_op_q;
    logic                epc_we_q;
    logic [31:0]         epc_w_q;
    logic                stall_q;
    logic                redirect_q;
    logic [31:0]         redirect_pc_q;
    logic                err_q;

    logic irq_ok;
    logic unused_ie;

    // Only the global enable bit of ie matters here.
    assign unused_ie = ^bus.ie[31:1];
    assign irq_ok    = bus.ivld & bus.ie[0] & ~guard_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            depth_q       <= '0;
            guard_q       <= 1'b0;
            num_q         <= '0;
            rc0_op_q      <= OP_NONE;
            epc_we_q      <= 1'b0;
            epc_w_q       <= '0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            // Output defaults are the IDLE values; states override below.
            rc0_op_q      <= OP_NONE;
            epc_we_q      <= 1'b0;
            epc_w_q       <= '0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_done) begin
                        // Any retired instruction releases the re-entry guard.
                        guard_q <= 1'b0;
                        if (bus.eret) begin
                            state_q <= StRet;
                            stall_q <= 1'b1;
                            if (depth_q == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                rc0_op_q      <= OP_RET;
                                redirect_q    <= 1'b1;
                                redirect_pc_q <= bus.epc;
                            end
                        end else if (irq_ok) begin
                            if (depth_q < DepthMax) begin
                                state_q  <= StEnter;
                                num_q    <= bus.inum;
                                rc0_op_q <= OP_IRQ;
                                epc_we_q <= 1'b1;
                                epc_w_q  <= bus.pc_next;
                                stall_q  <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                StEnter: begin
                    if (depth_q != DepthMax) begin
                        depth_q <= depth_q + DepthOne;
                    end
                    guard_q       <= 1'b1;
                    state_q       <= StVec;
                    stall_q       <= 1'b1;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= VEC_BASE + (32'(num_q) << VEC_SHIFT);
                end
                StVec: begin
                    state_q <= StIdle;
                end
                StRet: begin
                    if (depth_q != '0) begin
                        depth_q <= depth_q - DepthOne;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rc0_en      = 1'b1;
    assign bus.rc0_op      = rc0_op_q;
    assign bus.epc_we      = epc_we_q;
    assign bus.epc_w       = epc_w_q;
    assign bus.stall       = stall_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.depth       = depth_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_irq_seq_ctrl.sv
module tb_irq_seq_ctrl;
    localparam int MAXD = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic        epc_we;
        logic [31:0] epc_w;
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        err;
        logic [2:0]  depth;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    irq_seq_ctrl_if #(.NBIT_IRQ(5), .DEPTH_W(3)) bus ();

    irq_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    resp_t exp_q[$];

    // Reference model state: event-level view of the sequencer.
    int m_depth = 0;
    bit m_guard = 0;
    int m_busy  = 0;

    function automatic resp_t mk(logic [1:0] op, logic we, logic [31:0] ew, logic st,
                                 logic rd, logic [31:0] rpc, logic er, int d);
        resp_t r;
        r.op = op; r.epc_we = we; r.epc_w = ew; r.stall = st;
        r.redirect = rd; r.redirect_pc = rpc; r.err = er; r.depth = 3'(d);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One clock of stimulus; the model predicts responses for what the DUT will sample.
    task automatic step(input bit done, input bit er, input bit iv, input bit ie0,
                        input logic [4:0] num, input logic [31:0] pc, input logic [31:0] ep);
        @(posedge clk);
        #1;
        bus.instr_done = done;
        bus.eret       = er;
        bus.ivld       = iv;
        bus.ie         = {31'h0, ie0};
        bus.inum       = num;
        bus.pc_next    = pc;
        bus.epc        = ep;
        if (m_busy > 0) begin
            m_busy--;
        end else if (done) begin
            bit g;
            g = m_guard;
            m_guard = 0;
            if (er) begin
                if (m_depth == 0) begin
                    exp_q.push_back(mk(2'd0, 0, 0, 1, 0, 0, 1, 0));
                end else begin
                    exp_q.push_back(mk(2'd2, 0, 0, 1, 1, ep, 0, m_depth));
                    m_depth--;
                end
                m_busy = 1;
            end else if (iv && ie0 && !g) begin
                if (m_depth < MAXD) begin
                    exp_q.push_back(mk(2'd1, 1, pc, 1, 0, 0, 0, m_depth));
                    exp_q.push_back(mk(2'd0, 0, 0, 1, 1, 32'h800 + 32'(num) * 16, 0,
                                       m_depth + 1));
                    m_depth++;
                    m_guard = 1;
                    m_busy  = 2;
                end else begin
                    exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 1, m_depth));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rc0_en"}, 32'(bus.rc0_en), 32'd1);
        check({tag, "_quiet"}, {bus.rc0_op, bus.epc_we, bus.stall, bus.redirect, bus.err,
              bus.depth}, 32'd0);
        check({tag, "_epc_w"}, bus.epc_w, 32'd0);
        check({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
    endtask

    // Monitor: any cycle the DUT shows activity, pop the next expected response.
    initial begin
        resp_t got;
        resp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && (bus.stall || bus.err || bus.redirect || bus.epc_we ||
                          bus.rc0_op != 2'd0)) begin
                got = {bus.rc0_op, bus.epc_we, bus.epc_w, bus.stall, bus.redirect,
                       bus.redirect_pc, bus.err, bus.depth};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_response got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL response got op=%0d we=%0b ew=%h st=%0b rd=%0b rpc=%h er=%0b d=%0d want op=%0d we=%0b ew=%h st=%0b rd=%0b rpc=%h er=%0b d=%0d",
                                 got.op, got.epc_we, got.epc_w, got.stall, got.redirect,
                                 got.redirect_pc, got.err, got.depth, e.op, e.epc_we, e.epc_w,
                                 e.stall, e.redirect, e.redirect_pc, e.err, e.depth);
                    end
                end
            end
        end
    end

    initial begin
        bus.instr_done = 0; bus.eret = 0; bus.ivld = 0; bus.ie = 0;
        bus.inum = 0; bus.pc_next = 0; bus.epc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic entry: inum=3, pc 0x100 -> vector 0x830, depth 1.
        step(1, 0, 1, 1, 5'd3, 32'h100, 0);
        idle(4);
        check("depth_after_entry", 32'(bus.depth), 32'd1);
        // ERET back to 0x100.
        step(1, 1, 0, 1, 0, 0, 32'h100);
        idle(3);
        check("depth_after_eret", 32'(bus.depth), 32'd0);
        // ERET at depth 0 -> err only.
        step(1, 1, 0, 1, 0, 0, 32'h200);
        idle(3);
        // Global enable off: no entry.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0, 5'd7, 32'h300 + 32'(i * 4), 0);
            step(0, 0, 1, 0, 5'd7, 0, 0);
        end
        // ERET and irq at the same boundary: RET first, then entry.
        step(1, 1, 1, 1, 5'd2, 32'h400, 32'h0);
        step(1, 0, 1, 1, 5'd2, 32'h404, 0);
        step(1, 0, 1, 1, 5'd5, 32'h408, 0);
        idle(3);
        // Guard: ivld held without retire -> no re-entry.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 5'd9, 0, 0);
        check("depth_guard", 32'(bus.depth), 32'd1);
        // Nest up to MAX_DEPTH, then one more request -> err pulse.
        for (int i = 0; i < MAXD; i++) begin
            step(1, 0, 0, 1, 0, 0, 0);
            step(1, 0, 1, 1, 5'(i + 10), 32'h1000 + 32'(i * 16), 0);
            idle(3);
        end
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 5'd31, 32'h2000, 0);
        idle(2);
        check("depth_saturated", 32'(bus.depth), 32'(MAXD));
        for (int i = 0; i < MAXD + 1; i++) begin
            step(1, 1, 0, 1, 0, 0, 32'h3000 + 32'(i * 8));
            idle(1);
        end
        idle(2);

        // Randomized phase.
        for (int i = 0; i < 500; i++) begin
            bit d;
            d = ($urandom_range(0, 1) == 1);
            step(d, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 85), 5'($urandom), {$urandom, 2'b00} & 32'hFFFF_FFFC,
                 $urandom);
        end
        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during VEC: monitor consumes VEC at this posedge, then reset hits.
        while (m_depth >= MAXD) begin
            step(1, 1, 0, 1, 0, 0, 32'h44);
            idle(1);
        end
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 5'd6, 32'h500, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_depth = 0; m_guard = 0; m_busy = 0;
        #2;
        check_reset_outputs("midvec_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 1, 1, 5'd1, 32'h600, 0);
        idle(4);
        check("depth_post_reset", 32'(bus.depth), 32'd1);
        check("queue_final", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
